// File: rtl/jkff_bank_ctr.sv
// Bank of WIDTH JK flip-flops. The mode input selects each bit's J/K source:
// external j/k, up-count toggle terms, down-count toggle terms, or parallel load.
module jkff_bank_ctr #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             changed
);

  typedef enum logic [1:0] {
    M_JK   = 2'b00,
    M_UP   = 2'b01,
    M_DOWN = 2'b10,
    M_LOAD = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] up_t, dn_t;
  logic [WIDTH-1:0] j_eff, k_eff;

  assign mode_s = mode_e'(mode);

  // Toggle term of bit i: all lower bits one (up) or all lower bits zero (down).
  always_comb begin
    up_t = '0;
    dn_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      logic [WIDTH-1:0] lo;
      lo      = ~({WIDTH{1'b1}} << i);
      up_t[i] = ((q_q & lo) == lo);
      dn_t[i] = ((q_q & lo) == '0);
    end
  end

  always_comb begin
    j_eff = '0;
    k_eff = '0;
    unique case (mode_s)
      M_JK:   begin j_eff = j;    k_eff = k;    end
      M_UP:   begin j_eff = up_t; k_eff = up_t; end
      M_DOWN: begin j_eff = dn_t; k_eff = dn_t; end
      M_LOAD: begin j_eff = d;    k_eff = ~d;   end
      default: begin j_eff = '0;  k_eff = '0;   end
    endcase
    // Characteristic JK equation applied bitwise; en=0 forces hold.
    q_d       = en ? ((j_eff & ~q_q) | (~k_eff & q_q)) : q_q;
    changed_d = (q_d != q_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RST_VAL;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
    end
  end

  assign q       = q_q;
  assign qb      = ~q_q;
  assign changed = changed_q;
  assign tc      = ((mode_s == M_UP)   && (q_q == {WIDTH{1'b1}})) ||
                   ((mode_s == M_DOWN) && (q_q == '0));

endmodule
